// File: rtl/array_divider_pkg.sv
// Shared widths and constants for the 8/4 restoring array divider.
package array_divider_pkg;

   localparam int unsigned DW   = 8;        // dividend width
   localparam int unsigned QW   = 4;        // divisor / quotient / remainder width
   localparam int unsigned ROWS = 4;        // one row per quotient bit
   localparam int unsigned AW   = ROWS * QW; // one approximation enable per cell

   localparam logic [QW-1:0] OVF_Q = 4'hF;  // quotient reported on overflow

endpackage

// File: rtl/array_divider_if.sv
// Operand/result bundle of the array divider.
interface array_divider_if;
   import array_divider_pkg::*;

   logic [DW-1:0] x;
   logic [QW-1:0] y;
   logic [AW-1:0] a;
   logic [QW-1:0] q;
   logic [QW-1:0] r;

   modport master (output x, y, a, input  q, r);
   modport slave  (input  x, y, a, output q, r);

endinterface

// File: rtl/array_divider_cell.sv
// One subtractor cell of the divider array. With ARRAY_DIVIDER_APPROX_EN
// defined, app=1 replaces the difference by the inverted borrow-out;
// otherwise the cell is always exact and app is ignored.
module array_divider_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   input  logic app,
   output logic d,
   output logic bout
);

   // Borrow is identical for exact and approximate cells.
   assign bout = (~x & y) | (~x & bin) | (y & bin);

`ifdef ARRAY_DIVIDER_APPROX_EN
   // Approximate cell drops the XOR and reuses the borrow.
   assign d = app ? ~bout : (x ^ y ^ bin);
`else
   logic unused_app;
   assign unused_app = app;

   // Exact difference only.
   assign d = x ^ y ^ bin;
`endif

endmodule

// File: rtl/array_divider.sv
// 4x4 restoring array divider with registered quotient/remainder, 1-cycle
// latency. Optional per-cell approximation under ARRAY_DIVIDER_APPROX_EN.
module array_divider
   import array_divider_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   array_divider_if.slave bus
);

   logic [QW-1:0] q_c;
   logic [QW-1:0] r_c;
   logic          ovf_c;

`ifndef ARRAY_DIVIDER_APPROX_EN
   logic [AW-1:0] unused_a;
   assign unused_a = bus.a;
`endif

   // Exact overflow detection, independent of the approximation enables.
   assign ovf_c = (bus.y == '0) || (bus.x[DW-1 -: QW] >= bus.y);

   for (genvar j = 0; j < ROWS; j++) begin : g_row
      logic [QW-1:0] p_in;
      logic [QW:0]   t;
      logic [QW-1:0] dif;
      logic          qbit;
      logic [QW-1:0] p_out;

      if (j == 0) begin : g_first
         assign p_in = bus.x[DW-1 -: QW];
      end else begin : g_next
         assign p_in = g_row[j-1].p_out;
      end

      // Shift in the next dividend bit, MSB first.
      assign t = {p_in, bus.x[ROWS-1-j]};

      for (genvar i = 0; i < QW; i++) begin : g_cell
         logic bin;
         logic bo;
         logic app;

         if (i == 0) begin : g_lsb
            assign bin = 1'b0;
         end else begin : g_chain
            assign bin = g_cell[i-1].bo;
         end

`ifdef ARRAY_DIVIDER_APPROX_EN
         assign app = bus.a[QW*j+i];
`else
         assign app = 1'b0;
`endif

         array_divider_cell u_cell (
            .x    (t[i]),
            .y    (bus.y[i]),
            .bin  (bin),
            .app  (app),
            .d    (dif[i]),
            .bout (bo)
         );
      end

      // Quotient bit set when the shifted-out MSB or a borrow-free subtract.
      assign qbit  = t[QW] | ~g_cell[QW-1].bo;
      assign p_out = qbit ? dif : t[QW-1:0];
      assign q_c[QW-1-j] = qbit;
   end

   assign r_c = g_row[ROWS-1].p_out;

   // Output registers; reset wins over capture, overflow forces F/0.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.q <= '0;
         bus.r <= '0;
      end else if (ovf_c) begin
         bus.q <= OVF_Q;
         bus.r <= '0;
      end else begin
         bus.q <= q_c;
         bus.r <= r_c;
      end
   end

endmodule

// File: tb/tb_array_divider.sv
// Directed self-checking bench for array_divider.
module tb_array_divider;
   import array_divider_pkg::*;

   typedef struct {
      logic [DW-1:0] x;
      logic [QW-1:0] y;
      logic [AW-1:0] a;
      logic [QW-1:0] q;
      logic [QW-1:0] r;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   array_divider_if bus ();

   array_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [QW-1:0] eq, input logic [QW-1:0] er);
      tests++;
      if (bus.q !== eq || bus.r !== er) begin
         fails++;
         $display("FAIL %s: got q=%0d r=%0d, expected q=%0d r=%0d", name, bus.q, bus.r, eq, er);
      end
   endtask

   task automatic drive(input logic [DW-1:0] xv, input logic [QW-1:0] yv, input logic [AW-1:0] av);
      bus.x = xv;
      bus.y = yv;
      bus.a = av;
   endtask

   vec_t vecs [15];

   initial begin
      tests = 0;
      fails = 0;

      vecs[0]  = '{8'd8,   4'd4,  16'h0000, 4'd2,  4'd0};
      vecs[1]  = '{8'd7,   4'd3,  16'h0000, 4'd2,  4'd1};
      vecs[2]  = '{8'd5,   4'd5,  16'h0000, 4'd1,  4'd0};
      vecs[3]  = '{8'd40,  4'd13, 16'h0000, 4'd3,  4'd1};
      vecs[4]  = '{8'd17,  4'd5,  16'h0000, 4'd3,  4'd2};
      vecs[5]  = '{8'd16,  4'd4,  16'h0000, 4'd4,  4'd0};
      vecs[6]  = '{8'd20,  4'd5,  16'h0000, 4'd4,  4'd0};
`ifdef ARRAY_DIVIDER_APPROX_EN
      vecs[7]  = '{8'd8,   4'd4,  16'h8CEF, 4'd3,  4'd12};
`else
      vecs[7]  = '{8'd8,   4'd4,  16'h8CEF, 4'd2,  4'd0};
`endif
      vecs[8]  = '{8'd64,  4'd4,  16'h0000, 4'd15, 4'd0};
      vecs[9]  = '{8'd8,   4'd0,  16'h0000, 4'd15, 4'd0};
      vecs[10] = '{8'd64,  4'd4,  16'hFFFF, 4'd15, 4'd0};
      vecs[11] = '{8'd255, 4'd15, 16'h0000, 4'd15, 4'd0};
      vecs[12] = '{8'd239, 4'd15, 16'h0000, 4'd15, 4'd14};
      vecs[13] = '{8'd0,   4'd1,  16'h0000, 4'd0,  4'd0};
      vecs[14] = '{8'd15,  4'd1,  16'h0000, 4'd15, 4'd0};

      // Reset state with operands present.
      rst = 1'b1;
      drive(8'd7, 4'd3, 16'h0000);
      @(posedge clk); #1;
      check("reset_init", 4'd0, 4'd0);
      rst = 1'b0;

      // Table: each result one edge after the operands.
      for (int k = 0; k < 15; k++) begin
         drive(vecs[k].x, vecs[k].y, vecs[k].a);
         @(posedge clk); #1;
         check($sformatf("vec%0d_%0d_div_%0d", k, vecs[k].x, vecs[k].y), vecs[k].q, vecs[k].r);
      end

      // Mid-cycle operand change must not reach the outputs before the edge.
      drive(8'd8, 4'd4, 16'h0000);
      @(posedge clk); #1;
      check("hold_first", 4'd2, 4'd0);
      drive(8'd7, 4'd3, 16'h0000);
      #3;
      check("hold_midcycle", 4'd2, 4'd0);
      @(posedge clk); #1;
      check("hold_next_edge", 4'd2, 4'd1);

      // Reset during an active stream, then recovery on the next edge.
      drive(8'd40, 4'd13, 16'h0000);
      @(posedge clk); #1;
      check("stream_before_rst", 4'd3, 4'd1);
      rst = 1'b1;
      drive(8'd17, 4'd5, 16'h0000);
      @(posedge clk); #1;
      check("stream_rst_edge", 4'd0, 4'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("stream_after_rst", 4'd3, 4'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/array_divider.md
ARRAY_DIVIDER -- requirements
Module: array_divider

Interface
- Parameters: none; all widths fixed.
- REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
- REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-003 SHALL have port x, input, 8 bits: unsigned dividend.
- REQ-004 SHALL have port y, input, 4 bits: unsigned divisor.
- REQ-005 SHALL have port a, input, 16 bits: per-cell approximation enable; bit a[4*j+i] selects the cell at row j, bit i.
- REQ-006 SHALL have port q, output, 4 bits: registered quotient.
- REQ-007 SHALL have port r, output, 4 bits: registered remainder.

Function
- REQ-008 SHALL implement a 4-row by 4-cell restoring array divider.
  - Row 0 produces q[3]; row 3 produces q[0].
  - Bit i is the bit weight within a row; i=0 is the LSB.
- REQ-009 SHALL initialise the partial remainder P = x[7:4].
- REQ-010 SHALL, in row j, form the 5-bit value T = {P, x[3-j]}.
  - The row computes T[3:0] minus y through a ripple borrow chain, borrow-in 0 at bit 0.
  - The result is a 4-bit difference D and a borrow-out B.
- REQ-011 SHALL set the row's quotient bit to T[4] OR NOT B.
  - Next P = D when the quotient bit is 1; otherwise next P = T[3:0] (restore).
- REQ-012 SHALL make the exact cell compute:
  - d = x XOR y XOR bin;
  - bout = majority(NOT x, y, bin).
- REQ-013 SHALL make the approximate cell (a bit = 1) compute:
  - bout = majority(NOT x, y, bin), the same as the exact cell;
  - d = NOT bout.
- REQ-014 SHALL take r from the final P after row 3.
- REQ-015 SHALL be exact when a = 0.
  - Example: for any y != 0 and x[7:4] < y, q = x/y and r = x mod y.
- REQ-016 SHALL treat y = 0 or x[7:4] >= y as overflow.
  - Overflow is detected by an exact comparison, independent of a.
  - On overflow, q = 4'hF and r = 4'h0.
- REQ-017 SHALL register q and r on every rising clk edge from the current x, y and a.
  - Latency: exactly 1 cycle.
  - No handshake; a new operand set is accepted every cycle.
- REQ-018 SHALL keep the divider datapath purely combinational between the input ports and the output registers.
  - Input changes between edges have no effect until the next edge.

Reset
- REQ-019 SHALL clear q and r to 0 on any rising clk edge where rst = 1.
- REQ-020 SHALL give rst priority over a concurrent operand capture.
  - The first valid result appears on the first edge after rst deasserts.

Configuration
- REQ-021 SHALL honour the macro ARRAY_DIVIDER_APPROX_EN.
  - Defined: cells follow a as specified in REQ-013.
  - Undefined: a is ignored, all 16 cells are exact, and no approximate-cell logic is instantiated.

Structure
- REQ-022 SHALL place the following in the shared package array_divider_pkg:
  - constants: dividend width 8, divisor/quotient/remainder width 4, row count 4;
  - the overflow quotient value 4'hF.
- REQ-023 SHALL implement the cell as one sub-module, array_divider_cell.
  - Inputs: x, y, bin, app. Outputs: d, bout.
  - Instantiated 16 times; the row restore multiplexers stay in the top level.

Verification
- REQ-024 SHALL cover the exact mode with a = 0, each result one cycle after the operands are applied:
  - 8/4 -> q=2, r=0;
  - 7/3 -> q=2, r=1;
  - 5/5 -> q=1, r=0;
  - 40/13 -> q=3, r=1;
  - 17/5 -> q=3, r=2.
- REQ-025 SHALL cover exact mode with 16/4 -> q=4, r=0 and 20/5 -> q=4, r=0, since x[7:4] < y.
- REQ-026 SHALL cover the approximate mode with ARRAY_DIVIDER_APPROX_EN defined: a = 16'h8CEF, 8/4 -> q=3, r=12.
  - The same stimulus with the macro undefined -> q=2, r=0.
- REQ-027 SHALL cover overflow:
  - x=64, y=4 -> q=15, r=0;
  - x=8, y=0 -> q=15, r=0.
- REQ-028 SHALL cover reset:
  - rst=1 during an active stream -> q=0, r=0 on that edge;
  - after deassert, the next edge shows the result for the current operands.
